// File: rtl/backprop_pkg.sv
// rtl/backprop_pkg.sv - shared encodings and fixed-point constants for the backprop stages
package backprop_pkg;

    localparam int DENSE_LINEAR  = 0;
    localparam int DENSE_RELU    = 1;
    localparam int DENSE_LEAKY   = 2;
    localparam int DENSE_SIGMOID = 3;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Leaky slope is ONE>>6, hard-sigmoid slope is ONE/5 (truncated)
    localparam int LEAKY_SHIFT = 6;
    localparam int SIGMOID_DIV = 5;

    function automatic int fx_one(input int frac_bits);
        return 1 << frac_bits;
    endfunction

    // 2.5 in fixed point: the hard-sigmoid linear region is |z| < 2.5
    function automatic int sigmoid_limit(input int frac_bits);
        return 5 << (frac_bits - 1);
    endfunction

endpackage

// File: rtl/activate_diff_unit.sv
// rtl/activate_diff_unit.sv - combinational activation derivative f'(z) for one element
module activate_diff_unit
    import backprop_pkg::*;
#(
    parameter int data_size       = 16,
    parameter int frac_bits       = 8,
    parameter int dense_type_size = 4
) (
    input  logic signed [data_size-1:0]       z,
    input  logic        [dense_type_size-1:0] dense_type,
    output logic        [data_size-1:0]       dz,
    output logic                              bad
);

    localparam logic [data_size-1:0] ONE       = data_size'(fx_one(frac_bits));
    localparam logic [data_size-1:0] LEAK      = data_size'(fx_one(frac_bits) >> LEAKY_SHIFT);
    localparam logic [data_size-1:0] SIG_SLOPE = data_size'(fx_one(frac_bits) / SIGMOID_DIV);
    localparam logic [data_size:0]   SIG_LIMIT = (data_size+1)'(sigmoid_limit(frac_bits));

    logic [data_size:0] z_abs;
    logic               z_pos;

    // One extra bit so the most-negative input has a representable magnitude
    assign z_abs = z[data_size-1] ? (~{1'b1, z} + 1'b1) : {1'b0, z};
    assign z_pos = !z[data_size-1] && (z != '0);

    always_comb begin
        dz  = '0;
        bad = 1'b0;
        case (dense_type)
            dense_type_size'(DENSE_LINEAR):  dz = ONE;
            dense_type_size'(DENSE_RELU):    dz = z_pos ? ONE : '0;
            dense_type_size'(DENSE_LEAKY):   dz = z_pos ? ONE : LEAK;
            dense_type_size'(DENSE_SIGMOID): dz = (z_abs < SIG_LIMIT) ? SIG_SLOPE : '0;
            default:                         bad = 1'b1;
        endcase
    end

endmodule

// File: rtl/activate_diff_stage.sv
// rtl/activate_diff_stage.sv - serial activation-derivative stage with bundle pass-through
module activate_diff_stage
    import backprop_pkg::*;
#(
    parameter int size                   = 3,
    parameter int data_size              = 16,
    parameter int frac_bits              = 8,
    parameter int cost_type_size         = 8,
    parameter int dense_type_size        = 4,
    parameter int backprop_controll_size = 100
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [data_size*size-1:0]         predict_value,
    input  logic [cost_type_size-1:0]         cost_type,
    input  logic [dense_type_size-1:0]        dense_type,
    input  logic [data_size*size-1:0]         w,
    input  logic [data_size*size-1:0]         x,
    input  logic [data_size*size-1:0]         z,
    input  logic [backprop_controll_size-1:0] backprop_controll,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [data_size*size-1:0]         predict_value_out,
    output logic [cost_type_size-1:0]         cost_type_out,
    output logic [dense_type_size-1:0]        dense_type_out,
    output logic [data_size*size-1:0]         w_out,
    output logic [data_size*size-1:0]         x_out,
    output logic [data_size*size-1:0]         z_out,
    output logic [backprop_controll_size-1:0] backprop_controll_out,
    output logic [data_size*size-1:0]         dz_out,
    output logic                              bad_type
);

    localparam int IDX_W = (size > 1) ? $clog2(size) : 1;

    logic [1:0]                 state;
    logic [IDX_W-1:0]           idx;
    logic [data_size-1:0]       unit_z;
    logic [dense_type_size-1:0] unit_type;
    logic [data_size-1:0]       unit_dz;
    logic                       unit_bad;

    assign in_ready  = (state == ST_IDLE);
    assign out_valid = (state == ST_DONE);

    // In IDLE the unit sees the incoming type so bad_type is known at capture
    always_comb begin
        unit_type = (state == ST_IDLE) ? dense_type : dense_type_out;
        unit_z    = '0;
        for (int i = 0; i < size; i++) begin
            if (idx == IDX_W'(i)) unit_z = z_out[i*data_size +: data_size];
        end
    end

    activate_diff_unit #(
        .data_size       (data_size),
        .frac_bits       (frac_bits),
        .dense_type_size (dense_type_size)
    ) u_unit (
        .z          (unit_z),
        .dense_type (unit_type),
        .dz         (unit_dz),
        .bad        (unit_bad)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state                 <= ST_IDLE;
            idx                   <= '0;
            predict_value_out     <= '0;
            cost_type_out         <= '0;
            dense_type_out        <= '0;
            w_out                 <= '0;
            x_out                 <= '0;
            z_out                 <= '0;
            backprop_controll_out <= '0;
            dz_out                <= '0;
            bad_type              <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        predict_value_out     <= predict_value;
                        cost_type_out         <= cost_type;
                        dense_type_out        <= dense_type;
                        w_out                 <= w;
                        x_out                 <= x;
                        z_out                 <= z;
                        backprop_controll_out <= backprop_controll;
                        bad_type              <= unit_bad;
                        idx                   <= '0;
                        state                 <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    for (int i = 0; i < size; i++) begin
                        if (idx == IDX_W'(i)) dz_out[i*data_size +: data_size] <= unit_dz;
                    end
                    if (idx == IDX_W'(size - 1)) begin
                        idx   <= '0;
                        state <= ST_DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_activate_diff_stage.sv
// tb/tb_activate_diff_stage.sv - self-checking bench for activate_diff_stage
module tb_activate_diff_stage;

    localparam int ONE = 256;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [47:0]  predict_value = '0;
    logic [7:0]   cost_type = '0;
    logic [3:0]   dense_type = '0;
    logic [47:0]  w = '0;
    logic [47:0]  x = '0;
    logic [47:0]  z = '0;
    logic [99:0]  backprop_controll = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [47:0]  predict_value_out;
    logic [7:0]   cost_type_out;
    logic [3:0]   dense_type_out;
    logic [47:0]  w_out;
    logic [47:0]  x_out;
    logic [47:0]  z_out;
    logic [99:0]  backprop_controll_out;
    logic [47:0]  dz_out;
    logic         bad_type;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    activate_diff_stage dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .in_valid              (in_valid),
        .in_ready              (in_ready),
        .predict_value         (predict_value),
        .cost_type             (cost_type),
        .dense_type            (dense_type),
        .w                     (w),
        .x                     (x),
        .z                     (z),
        .backprop_controll     (backprop_controll),
        .out_valid             (out_valid),
        .out_ready             (out_ready),
        .predict_value_out     (predict_value_out),
        .cost_type_out         (cost_type_out),
        .dense_type_out        (dense_type_out),
        .w_out                 (w_out),
        .x_out                 (x_out),
        .z_out                 (z_out),
        .backprop_controll_out (backprop_controll_out),
        .dz_out                (dz_out),
        .bad_type              (bad_type)
    );

    typedef struct packed {
        logic [3:0]  t;
        logic [47:0] z;
        logic [47:0] dz;
        logic        bad;
    } vec_t;

    vec_t vecs[8];

    function automatic logic [47:0] mk3(input logic [15:0] a0, input logic [15:0] a1, input logic [15:0] a2);
        return {a2, a1, a0};
    endfunction

    // Reference derivative straight from the activation rules, in integer arithmetic
    function automatic logic [15:0] ref_dz(input logic [15:0] zb, input int t);
        int zi;
        int az;
        zi = int'($signed(zb));
        az = (zi < 0) ? -zi : zi;
        case (t)
            0: return 16'(ONE);
            1: return (zi > 0) ? 16'(ONE) : 16'd0;
            2: return (zi > 0) ? 16'(ONE) : 16'(ONE / 64);
            3: return (2 * az < 5 * ONE) ? 16'(ONE / 5) : 16'd0;
            default: return 16'd0;
        endcase
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic randomize_passthru();
        logic [127:0] r;
        r = {$urandom, $urandom, $urandom, $urandom};
        backprop_controll = r[99:0];
        r = {$urandom, $urandom, $urandom, $urandom};
        predict_value = r[47:0];
        w = r[95:48];
        r = {$urandom, $urandom, $urandom, $urandom};
        x = r[47:0];
        cost_type = r[55:48];
    endtask

    // Present a bundle, wait for its capture, and return the cycles until out_valid
    task automatic capture_and_wait(output int lat);
        int n;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("in_ready_before_capture", 128'(in_ready), 128'(1));
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("out_valid_after_handshake", 128'(out_valid), 128'(0));
        chk("in_ready_after_handshake", 128'(in_ready), 128'(1));
    endtask

    task automatic check_bundle(input string tag, input logic [47:0] exp_dz, input logic exp_bad);
        chk({tag, "_dz"}, 128'(dz_out), 128'(exp_dz));
        chk({tag, "_bad"}, 128'(bad_type), 128'(exp_bad));
        chk({tag, "_out_valid"}, 128'(out_valid), 128'(1));
        chk({tag, "_in_ready"}, 128'(in_ready), 128'(0));
    endtask

    initial begin
        int lat;
        logic [47:0] exp_dz;
        logic [47:0] held_dz;
        logic [47:0] held_w;
        logic [99:0] held_ctl;
        logic [3:0]  t;

        vecs[0] = '{4'd1, mk3(16'h0200, 16'h0000, 16'hFF00), mk3(16'h0100, 16'h0000, 16'h0000), 1'b0};
        vecs[1] = '{4'd3, mk3(16'h0280, 16'h027F, 16'h8000), mk3(16'h0000, 16'h0033, 16'h0000), 1'b0};
        vecs[2] = '{4'd2, mk3(16'hFF00, 16'h0001, 16'h0000), mk3(16'h0004, 16'h0100, 16'h0004), 1'b0};
        vecs[3] = '{4'd0, mk3(16'h8000, 16'h7FFF, 16'h0000), mk3(16'h0100, 16'h0100, 16'h0100), 1'b0};
        vecs[4] = '{4'd7, mk3(16'h0200, 16'hFF00, 16'h0010), mk3(16'h0000, 16'h0000, 16'h0000), 1'b1};
        vecs[5] = '{4'd0, mk3(16'h1234, 16'hF000, 16'h0000), mk3(16'h0100, 16'h0100, 16'h0100), 1'b0};
        vecs[6] = '{4'd3, mk3(16'hFD81, 16'hFD80, 16'h7FFF), mk3(16'h0033, 16'h0000, 16'h0000), 1'b0};
        vecs[7] = '{4'd15, mk3(16'h0001, 16'h0002, 16'h0003), mk3(16'h0000, 16'h0000, 16'h0000), 1'b1};

        #2;
        chk("reset_in_ready", 128'(in_ready), 128'(1));
        chk("reset_out_valid", 128'(out_valid), 128'(0));
        chk("reset_dz", 128'(dz_out), 128'(0));
        chk("reset_bad_type", 128'(bad_type), 128'(0));
        chk("reset_ctl", 128'(backprop_controll_out), 128'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 8; i++) begin
            randomize_passthru();
            dense_type = vecs[i].t;
            z = vecs[i].z;
            capture_and_wait(lat);
            chk($sformatf("vec%0d_latency", i), 128'(lat), 128'(3));
            check_bundle($sformatf("vec%0d", i), vecs[i].dz, vecs[i].bad);
            chk($sformatf("vec%0d_z_out", i), 128'(z_out), 128'(vecs[i].z));
            handshake();
        end

        for (int n = 0; n < 40; n++) begin
            randomize_passthru();
            t = ($urandom_range(0, 9) < 8) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(4, 15));
            dense_type = t;
            for (int e = 0; e < 3; e++) begin
                case ($urandom_range(0, 3))
                    0: z[e*16 +: 16] = 16'($urandom);
                    1: z[e*16 +: 16] = 16'($urandom_range(0, 1300)) - 16'd650;
                    2: z[e*16 +: 16] = 16'h8000;
                    default: z[e*16 +: 16] = 16'($urandom_range(0, 2));
                endcase
                exp_dz[e*16 +: 16] = ref_dz(z[e*16 +: 16], int'(t));
            end
            capture_and_wait(lat);
            chk($sformatf("rnd%0d_latency", n), 128'(lat), 128'(3));
            check_bundle($sformatf("rnd%0d", n), exp_dz, t > 4'd3);
            chk($sformatf("rnd%0d_predict", n), 128'(predict_value_out), 128'(predict_value));
            chk($sformatf("rnd%0d_w", n), 128'(w_out), 128'(w));
            chk($sformatf("rnd%0d_x", n), 128'(x_out), 128'(x));
            chk($sformatf("rnd%0d_z", n), 128'(z_out), 128'(z));
            chk($sformatf("rnd%0d_cost", n), 128'(cost_type_out), 128'(cost_type));
            chk($sformatf("rnd%0d_type", n), 128'(dense_type_out), 128'(t));
            chk($sformatf("rnd%0d_ctl", n), 128'(backprop_controll_out), 128'(backprop_controll));
            handshake();
        end

        // Backpressure: outputs must hold and a new bundle must not be taken
        randomize_passthru();
        dense_type = 4'd1;
        z = mk3(16'h0200, 16'h0000, 16'hFF00);
        capture_and_wait(lat);
        held_dz = dz_out;
        held_w = w;
        held_ctl = backprop_controll;
        chk("bp_dz", 128'(held_dz), 128'(mk3(16'h0100, 16'h0000, 16'h0000)));
        w = ~w;
        backprop_controll = ~backprop_controll;
        z = mk3(16'h0100, 16'h0100, 16'h0100);
        dense_type = 4'd0;
        in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            chk($sformatf("bp%0d_out_valid", c), 128'(out_valid), 128'(1));
            chk($sformatf("bp%0d_in_ready", c), 128'(in_ready), 128'(0));
            chk($sformatf("bp%0d_dz", c), 128'(dz_out), 128'(held_dz));
            chk($sformatf("bp%0d_w", c), 128'(w_out), 128'(held_w));
            chk($sformatf("bp%0d_ctl", c), 128'(backprop_controll_out), 128'(held_ctl));
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid = 1'b0;
        chk("bp_release_out_valid", 128'(out_valid), 128'(0));
        chk("bp_release_w_held", 128'(w_out), 128'(held_w));
        chk("bp_release_dz_held", 128'(dz_out), 128'(held_dz));

        // Reset while in CALC with idx=1
        @(posedge clk); #1;
        dense_type = 4'd2;
        z = mk3(16'hFF00, 16'hFF00, 16'hFF00);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_out_valid", 128'(out_valid), 128'(0));
        chk("rst_mid_dz", 128'(dz_out), 128'(0));
        chk("rst_mid_in_ready", 128'(in_ready), 128'(1));
        chk("rst_mid_bad_type", 128'(bad_type), 128'(0));
        #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
        randomize_passthru();
        dense_type = 4'd3;
        z = mk3(16'h0000, 16'hFD80, 16'h0100);
        capture_and_wait(lat);
        chk("post_rst_latency", 128'(lat), 128'(3));
        check_bundle("post_rst", mk3(16'h0033, 16'h0000, 16'h0033), 1'b0);
        chk("post_rst_ctl", 128'(backprop_controll_out), 128'(backprop_controll));
        handshake();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
